confreg_resp: RTL and testbench
===============================

# confreg_resp

Memory-mapped configuration-register responder on the CPU data SRAM port. It decodes physical (post-MMU) data accesses in one 64 KB window and serves LED, seven-segment, switch, timer, compare and interrupt registers with fixed one-cycle read latency. It drives the timer interrupt onto the core's `ext_int` vector. It sits in the SoC beside the data RAM; the SoC's read-data mux selects it on a window hit.

## Interface
- `BASE_ADDR`, default `32'h1faf_0000`: window base; only bits [31:16] are compared.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `data_sram_en` in 1: access request valid this cycle.
- `data_sram_wen` in 4: byte write enables; nonzero means write, zero means read.
- `data_sram_addr` in 32: physical byte address.
- `data_sram_wdata` in 32: write data.
- `data_sram_rdata` out 32: read data, registered.
- `hit` out 1: registered; 1 when the previous cycle's request hit the window (mux select).
- `ext_int` out 6: interrupt lines to the core.
- `led` out 16: LED register.
- `num_data` out 32: seven-segment value.
- `switch` in 8: asynchronous board switches.

## Operation
- Hit condition: `data_sram_en && data_sram_addr[31:16] == BASE_ADDR[31:16]`.
- Non-hit requests are ignored, and `data_sram_rdata` holds its value.
- Register map (offset = `addr[15:0]`, word-aligned, `addr[1:0]` ignored):
  - 0xE000 TIMER, R/W, reset 0.
  - 0xE004 COMPARE, R/W, reset 0xFFFF_FFFF.
  - 0xE008 INT_STATUS, bit0 pending, write-1-to-clear.
  - 0xE00C INT_ENABLE, bit0 enable, reset 0.
  - 0xF000 LED, R/W [15:0].
  - 0xF010 NUM, R/W.
  - 0xF020 SWITCH, read-only, zero-extended.
  - Every other offset reads 0; writes to it are dropped.
- Writes merge byte lanes: byte k is updated only where `wen[k]`=1. Read-only bits and unused upper bits are never written and always read 0.
- TIMER increments by 1 every cycle and wraps 0xFFFF_FFFF→0. A write in a cycle replaces the increment for that cycle; merged bytes come from the pre-increment value.
- Compare match: when the current TIMER value equals COMPARE, INT_STATUS[0] is set at the next edge.
- If a match set and a W1C clear of INT_STATUS[0] occur in the same cycle, the set wins.
- `ext_int[5] = INT_STATUS[0] & INT_ENABLE[0]`, an AND of register outputs. `ext_int[4:0]` are tied to 0.
- SWITCH path: two-flop synchroniser, reset 0.
- Reset values of outputs: `data_sram_rdata`=0, `hit`=0, `ext_int`=0, `led`=0, `num_data`=0. Internal registers reset as listed in the map; INT_STATUS resets to 0.
- `resetn` asserted mid-operation clears all state immediately, regardless of `clk`.

## Timing
- Read latency is 1: a request at edge N yields `data_sram_rdata` and `hit` valid after edge N, for use in cycle N+1.
- TIMER reads return the value held before edge N, i.e. the pre-increment value.
- A write at edge N is visible to a read request issued in cycle N+1.
- Write cycles do not update `data_sram_rdata`; `hit` still reflects the write.
- Interrupt: TIMER==COMPARE during cycle N → pending set at edge N → `ext_int[5]` high in cycle N+1, if enabled.
- A W1C at edge M drops `ext_int[5]` in cycle M+1, unless a match occurred in cycle M.
- Requests are accepted every cycle with no stall and no back-pressure.

## Configuration
- `CONFREG_TIMER_EN` defined: TIMER, COMPARE, INT_STATUS and INT_ENABLE are present, and `ext_int[5]` is driven as above.
- `CONFREG_TIMER_EN` undefined: the four registers are not synthesised. Their offsets read 0, writes to them are dropped, and `ext_int` is constant 6'b0. The LED, NUM and SWITCH registers are unaffected.

## Test plan
- Reset, then read 0xE004 and 0xF000 → rdata 0xFFFF_FFFF and 0x0000_0000. `ext_int`=0 and `hit`=1 in each response cycle.
- Write 0x1faf_f010 with wen=4'b0101 and wdata=0xAABBCCDD, then read it back → rdata 0x00BB00DD and `num_data`=0x00BB00DD.
- Write TIMER=0x10 at edge N, then read TIMER at edge N+3 → rdata 0x12.
- Checks after TIMER wrap: write TIMER=0xFFFF_FFFE, then after 2 cycles the timer reads around 0x0000_0000 with no stall.
- Interrupt sequence:
  - Set INT_ENABLE=1, COMPARE=0x20, TIMER=0x1E at edge N.
  - `ext_int[5]` rises in cycle N+4.
  - A W1C of INT_STATUS drops it the cycle after the W1C edge.
  - With TIMER==COMPARE in the W1C cycle itself, `ext_int[5]` stays 1.
- Out-of-window and corner-case accesses:
  - Read 0x1fb0_f000 → `hit`=0 and rdata unchanged.
  - Drive `switch`=0x5A and read 0xF020 at least 3 cycles later → rdata 0x5A.
  - Assert `resetn`=0 mid-sequence → all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/confreg_resp_if.sv
// Data SRAM port bundle between the CPU (master) and the config-register responder (slave).
// A request is qualified by en; a nonzero wen marks it as a write.
interface confreg_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        hit;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, hit
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, hit
  );
endinterface

// File: rtl/confreg_resp.sv
// Config-register responder in a 64 KB window of the data SRAM port; one-cycle read latency.
// Define CONFREG_TIMER_EN to build TIMER/COMPARE/INT_STATUS/INT_ENABLE and drive ext_int[5].
module confreg_resp #(
  parameter logic [31:0] BASE_ADDR = 32'h1faf_0000
) (
  input  logic          clk,
  input  logic          resetn,
  confreg_resp_if.slave bus,
  output logic [5:0]    ext_int,
  output logic [15:0]   led,
  output logic [31:0]   num_data,
  input  logic [7:0]    switch
);
  localparam logic [15:0] OFF_TIMER      = 16'he000;
  localparam logic [15:0] OFF_COMPARE    = 16'he004;
  localparam logic [15:0] OFF_INT_STATUS = 16'he008;
  localparam logic [15:0] OFF_INT_ENABLE = 16'he00c;
  localparam logic [15:0] OFF_LED        = 16'hf000;
  localparam logic [15:0] OFF_NUM        = 16'hf010;
  localparam logic [15:0] OFF_SWITCH     = 16'hf020;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wen);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++)
      if (wen[k]) res[8*k +: 8] = wdata[8*k +: 8];
    return res;
  endfunction

  logic        req_hit;
  logic        req_wr;
  logic        req_rd;
  logic [15:0] offset;
  logic [31:0] rd_data;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [1:0]  unused_addr_lsb;

  assign req_hit = bus.data_sram_en && (bus.data_sram_addr[31:16] == BASE_ADDR[31:16]);
  assign req_wr  = req_hit && (bus.data_sram_wen != 4'b0000);
  assign req_rd  = req_hit && (bus.data_sram_wen == 4'b0000);
  assign offset  = {bus.data_sram_addr[15:2], 2'b00};
  assign unused_addr_lsb = bus.data_sram_addr[1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led      <= '0;
      num_data <= '0;
    end else if (req_wr) begin
      if (offset == OFF_LED) begin
        if (bus.data_sram_wen[0]) led[7:0]  <= bus.data_sram_wdata[7:0];
        if (bus.data_sram_wen[1]) led[15:8] <= bus.data_sram_wdata[15:8];
      end
      if (offset == OFF_NUM)
        num_data <= merge_bytes(num_data, bus.data_sram_wdata, bus.data_sram_wen);
    end
  end

`ifdef CONFREG_TIMER_EN
  logic [31:0] timer;
  logic [31:0] compare;
  logic        int_pending;
  logic        int_enable;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer       <= '0;
      compare     <= '1;
      int_pending <= 1'b0;
      int_enable  <= 1'b0;
    end else begin
      // A write replaces this cycle's increment; merged bytes come from the current count.
      if (req_wr && offset == OFF_TIMER)
        timer <= merge_bytes(timer, bus.data_sram_wdata, bus.data_sram_wen);
      else
        timer <= timer + 32'd1;
      if (req_wr && offset == OFF_COMPARE)
        compare <= merge_bytes(compare, bus.data_sram_wdata, bus.data_sram_wen);
      if (req_wr && offset == OFF_INT_ENABLE && bus.data_sram_wen[0])
        int_enable <= bus.data_sram_wdata[0];
      // Match set has priority over a same-cycle W1C.
      if (timer == compare)
        int_pending <= 1'b1;
      else if (req_wr && offset == OFF_INT_STATUS && bus.data_sram_wen[0] && bus.data_sram_wdata[0])
        int_pending <= 1'b0;
    end
  end

  assign ext_int = {int_pending & int_enable, 5'b00000};
`else
  assign ext_int = 6'b000000;
`endif

  // NOTE: every variable in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (offset)
`ifdef CONFREG_TIMER_EN
      OFF_TIMER:      rd_data = timer;
      OFF_COMPARE:    rd_data = compare;
      OFF_INT_STATUS: rd_data = {31'b0, int_pending};
      OFF_INT_ENABLE: rd_data = {31'b0, int_enable};
`endif
      OFF_LED:        rd_data = {16'b0, led};
      OFF_NUM:        rd_data = num_data;
      OFF_SWITCH:     rd_data = {24'b0, sw_sync};
      default:        rd_data = '0;
    endcase
  end

  // NOTE: the reset is asynchronous, so outputs clear as soon as resetn falls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.data_sram_rdata <= '0;
      bus.hit             <= 1'b0;
    end else begin
      bus.hit <= req_hit;
      if (req_rd) bus.data_sram_rdata <= rd_data;
    end
  end
endmodule

// File: tb/tb_confreg_resp.sv
// Self-checking bench for confreg_resp: scoreboard of expected responses, checked one cycle later.
// Timer expectations follow CONFREG_TIMER_EN so the bench suits either build.
module tb_confreg_resp;
`ifdef CONFREG_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif
  localparam logic [31:0] BASE = 32'h1faf_0000;

  typedef struct {
    logic        hit;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [5:0]  ext_int;
  logic [15:0] led;
  logic [31:0] num_data;
  logic [7:0]  switch;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];
  logic [31:0] last_rdata;

  confreg_resp_if bus ();

  confreg_resp #(.BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .ext_int  (ext_int),
    .led      (led),
    .num_data (num_data),
    .switch   (switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one request for one clock edge; the expected response is queued now, checked after the edge.
  task automatic access(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
    exp_t e;
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    e.hit   = en && (addr[31:16] == BASE[31:16]);
    e.rdata = (e.hit && wen == 4'b0000) ? exp_rd : last_rdata;
    last_rdata = e.rdata;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, ".hit"}, {31'b0, bus.hit}, {31'b0, e.hit});
    check({tag, ".rdata"}, bus.data_sram_rdata, e.rdata);
  endtask

  task automatic wr(input logic [15:0] off, input logic [3:0] wen, input logic [31:0] data, input string tag);
    access(1'b1, wen, BASE | {16'b0, off}, data, 32'h0, tag);
  endtask

  task automatic rd(input logic [15:0] off, input logic [31:0] exp, input string tag);
    access(1'b1, 4'b0000, BASE | {16'b0, off}, 32'h0, exp, tag);
  endtask

  task automatic idle(input string tag);
    access(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, tag);
  endtask

  task automatic check_int(input logic exp, input string tag);
    check(tag, {26'b0, ext_int}, {26'b0, (TIMER_EN && exp), 5'b0});
  endtask

  initial begin
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 4'b0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;
    switch = 8'h00;
    resetn = 1'b1;
    last_rdata = 32'h0;
    #1 resetn = 1'b0;
    #1;
    check("reset.rdata", bus.data_sram_rdata, 32'h0);
    check("reset.hit", {31'b0, bus.hit}, 32'h0);
    check("reset.ext_int", {26'b0, ext_int}, 32'h0);
    check("reset.led", {16'b0, led}, 32'h0);
    check("reset.num", num_data, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Reset values through the read path
    rd(16'he004, TIMER_EN ? 32'hffff_ffff : 32'h0, "rd_compare_rst");
    check_int(1'b0, "rst.ext_int");
    rd(16'hf000, 32'h0, "rd_led_rst");
    check_int(1'b0, "rst.ext_int2");

    // Byte-lane merge on NUM; addr[1:0] is ignored
    wr(16'hf010, 4'b0101, 32'haabb_ccdd, "wr_num");
    rd(16'hf010, 32'h00bb_00dd, "rd_num");
    check("num_data", num_data, 32'h00bb_00dd);
    wr(16'hf012, 4'b1000, 32'h1100_0000, "wr_num_hi");
    rd(16'hf013, 32'h11bb_00dd, "rd_num_unaligned");

    // LED: only the low 16 bits exist
    wr(16'hf000, 4'b1111, 32'h1234_5678, "wr_led");
    rd(16'hf000, 32'h0000_5678, "rd_led");
    wr(16'hf000, 4'b0010, 32'hffff_ab00, "wr_led_b1");
    check("led_b1", {16'b0, led}, 32'h0000_ab78);
    wr(16'hf000, 4'b1100, 32'hffff_ffff, "wr_led_upper");
    rd(16'hf000, 32'h0000_ab78, "rd_led_upper");

    // Unmapped offsets read 0 and drop writes
    wr(16'hf004, 4'b1111, 32'hdead_beef, "wr_unmapped");
    rd(16'hf004, 32'h0, "rd_unmapped");
    rd(16'he010, 32'h0, "rd_unmapped2");

    // Out-of-window and idle requests leave rdata alone
    rd(16'hf010, 32'h11bb_00dd, "rd_num_again");
    access(1'b1, 4'b0000, 32'h1fb0_f000, 32'h0, 32'h0, "rd_outside");
    access(1'b0, 4'b0000, BASE | 32'hf000, 32'h0, 32'h0, "rd_no_en");

    // Switch synchroniser
    switch = 8'h5a;
    idle("sw_wait0");
    idle("sw_wait1");
    idle("sw_wait2");
    rd(16'hf020, 32'h0000_005a, "rd_switch");

    // Timer read-back: written at edge N, read at edge N+3
    wr(16'he000, 4'b1111, 32'h0000_0010, "wr_timer");
    idle("tmr_wait0");
    idle("tmr_wait1");
    rd(16'he000, TIMER_EN ? 32'h12 : 32'h0, "rd_timer");

    // Wrap with back-to-back reads
    wr(16'he000, 4'b1111, 32'hffff_fffe, "wr_timer_wrap");
    rd(16'he000, TIMER_EN ? 32'hffff_fffe : 32'h0, "rd_wrap0");
    rd(16'he000, TIMER_EN ? 32'hffff_ffff : 32'h0, "rd_wrap1");
    rd(16'he000, 32'h0, "rd_wrap2");

    // The wrap passed COMPARE=0xFFFFFFFF: pending is set but masked
    rd(16'he008, TIMER_EN ? 32'h1 : 32'h0, "rd_status_set");
    check_int(1'b0, "masked.ext_int");
    wr(16'he008, 4'b0001, 32'h1, "w1c_status");
    rd(16'he008, 32'h0, "rd_status_clr");

    // Interrupt: enable, compare=0x20, timer=0x1E at edge N
    wr(16'he00c, 4'b0001, 32'h1, "wr_int_en");
    wr(16'he004, 4'b1111, 32'h20, "wr_compare");
    wr(16'he000, 4'b1111, 32'h1e, "wr_timer_1e");
    check_int(1'b0, "irq.n0");
    idle("irq_w1");
    check_int(1'b0, "irq.n1");
    idle("irq_w2");
    check_int(1'b0, "irq.n2");
    idle("irq_w3");
    check_int(1'b1, "irq.n3");
    rd(16'he00c, TIMER_EN ? 32'h1 : 32'h0, "rd_int_en");
    wr(16'he008, 4'b0001, 32'h1, "w1c_irq");
    check_int(1'b0, "irq.cleared");

    // Set wins over a W1C in the match cycle
    wr(16'he000, 4'b1111, 32'h1f, "wr_timer_1f");
    check_int(1'b0, "race.k0");
    idle("race_w1");
    check_int(1'b0, "race.k1");
    wr(16'he008, 4'b0001, 32'h1, "w1c_race");
    check_int(1'b1, "race.set_wins");
    idle("race_w2");
    check_int(1'b1, "race.held");
    wr(16'he008, 4'b0001, 32'h1, "w1c_final");
    check_int(1'b0, "race.cleared");
    rd(16'he004, TIMER_EN ? 32'h20 : 32'h0, "rd_compare");

    // Asynchronous reset mid-sequence
    rd(16'hf010, 32'h11bb_00dd, "rd_before_reset");
    #2 resetn = 1'b0;
    #1;
    check("areset.rdata", bus.data_sram_rdata, 32'h0);
    check("areset.hit", {31'b0, bus.hit}, 32'h0);
    check("areset.ext_int", {26'b0, ext_int}, 32'h0);
    check("areset.led", {16'b0, led}, 32'h0);
    check("areset.num", num_data, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    last_rdata = 32'h0;
    rd(16'hf010, 32'h0, "rd_num_after_rst");
    rd(16'he004, TIMER_EN ? 32'hffff_ffff : 32'h0, "rd_compare_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
